alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter TAG_W, default 4, giving the width of the opaque tag carried from request to response.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 reqN_valid  input  1  (N = 0,1) requester N presents an operation.
REQ-005 reqN_ready  output  1  operation of requester N is accepted this cycle.
REQ-006 reqN_rs1, reqN_rs2  input  32 each  operands.
REQ-007 reqN_ctrl  input  4  op code: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
REQ-008 reqN_tag  input  TAG_W  opaque tag.
REQ-009 rsp_valid  output  1  result register holds a valid result.
REQ-010 rsp_ready  input  1  consumer takes the result.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_tag  output  TAG_W  tag of the owning request.
REQ-013 rsp_rd  output  32  ALU result.
REQ-014 rsp_zero  output  1  equals 1 when rs1 == rs2.

Function
REQ-015 The block SHALL contain one shared ALU instance and one output register stage, using states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-016 The block SHALL set can_accept = !rsp_valid | rsp_ready.
REQ-017 The grant SHALL depend only on reqN_valid and the priority state, never on rsp_ready; reqN_ready = grant_N & can_accept.
REQ-018 The block SHALL grant at most one requester per cycle; a requester whose valid is low SHALL never be granted.
REQ-019 A request accepted at edge k SHALL appear at the outputs after edge k, with rsp_valid=1 and rd/zero/id/tag captured from the granted request: 1-cycle latency.
REQ-020 Sustained throughput SHALL be 1 operation per cycle when rsp_ready is held high.
REQ-021 The block SHALL compute rd per REQ-007 as follows.
  - Shifts use rs2[4:0].
  - SLT is signed and SLTU is unsigned, each giving 0 or 1.
  - SRA is arithmetic.
  - Any unlisted code gives rd=0.
  - All results are modulo 2^32.
REQ-022 While FULL and rsp_ready=0, rsp_* SHALL hold stable and both reqN_ready SHALL be 0.
REQ-023 FULL with rsp_ready=1 and a grant SHALL load the new result on the same edge and stay FULL, with no bubble.
REQ-024 FULL with rsp_ready=1 and no request valid SHALL go to EMPTY.
REQ-025 EMPTY with no request SHALL remain EMPTY; rsp_rd, rsp_zero, rsp_id and rsp_tag keep their last values.
REQ-026 The priority state SHALL change only on an accepted transfer, never on a stalled grant.

Reset
REQ-027 On rst=1 the block SHALL asynchronously clear rsp_valid, rsp_rd, rsp_zero, rsp_id and rsp_tag to 0 and set priority to requester 0.
REQ-028 A result pending at reset SHALL be discarded, and reqN_ready SHALL be 0 while rst=1.

Configuration
REQ-029 With macro ALU_ARBITER_RR_EN defined, arbitration SHALL be round-robin.
  - When both requesters are valid, the one not granted last wins.
  - After each accepted transfer, priority moves to the other requester.
REQ-030 Without ALU_ARBITER_RR_EN, arbitration SHALL be fixed priority with requester 0 always winning, and the priority state SHALL not exist.

Verification
REQ-031 Reset check: assert rst mid-FULL with rsp_ready=0 -> rsp_valid=0 and rsp_rd=0 immediately, with no clock edge needed.
REQ-032 Single op: req0 SUB rs1=5, rs2=7, tag=3 -> next cycle rsp_valid=1, rd=0xFFFFFFFE, zero=0, id=0, tag=3.
REQ-033 Op coverage:
  - SRA rs1=0x80000000, rs2=0x24 -> rd=0xF8000000.
  - SLTU rs1=0xFFFFFFFF, rs2=1 -> rd=0.
  - SLT with the same operands -> rd=1.
REQ-034 Contention with both valid continuously for 4 cycles and rsp_ready=1:
  - With RR_EN, ids are 0,1,0,1.
  - Without RR_EN, ids are 0,0,0,0 and req1_ready stays 0.
REQ-035 Backpressure: hold rsp_ready=0 for 3 cycles while FULL -> outputs stable and both readys 0; then rsp_ready=1 with req1 valid -> result swapped on the same edge, rsp_valid stays 1.
REQ-036 Stall fairness (RR_EN): grant req1 while stalled for 2 cycles, then drain -> req1 accepted and priority advances only once.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared ALU with a single registered response stage.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; the default build is fixed priority (requester 0 wins).
module alu_arbiter #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_rs1,
    input  logic [31:0]      req0_rs2,
    input  logic [3:0]       req0_ctrl,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_rs1,
    input  logic [31:0]      req1_rs2,
    input  logic [3:0]       req1_ctrl,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_rd,
    output logic             rsp_zero
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    logic              can_accept;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic [XLEN-1:0]   sel_rs1;
    logic [XLEN-1:0]   sel_rs2;
    logic [3:0]        sel_ctrl;
    logic [TAG_W-1:0]  sel_tag;
    logic [XLEN-1:0]   alu_rd;
    logic              alu_zero;

    function automatic logic [XLEN-1:0] alu_op(input logic [3:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [4:0] shamt;
        shamt = b[4:0];
        case (op)
            4'b0000: alu_op = a + b;
            4'b1000: alu_op = a - b;
            4'b0001: alu_op = a << shamt;
            4'b0010: alu_op = XLEN'($signed(a) < $signed(b));
            4'b0011: alu_op = XLEN'(a < b);
            4'b0100: alu_op = a ^ b;
            4'b0101: alu_op = a >> shamt;
            4'b1101: alu_op = XLEN'($signed(a) >>> shamt);
            4'b0110: alu_op = a | b;
            4'b0111: alu_op = a & b;
            default: alu_op = '0;
        endcase
    endfunction

    assign rsp_valid  = (state == FULL);
    assign can_accept = !rsp_valid | rsp_ready;

`ifdef ALU_ARBITER_RR_EN
    // prio=1 means requester 1 is favoured on the next contended cycle
    logic prio;
    assign grant0 = req0_valid & (!req1_valid | !prio);
    assign grant1 = req1_valid & (!req0_valid |  prio);
`else
    assign grant0 = req0_valid;
    assign grant1 = req1_valid & !req0_valid;
`endif

    assign req0_ready = grant0 & can_accept & !rst;
    assign req1_ready = grant1 & can_accept & !rst;
    assign accept     = req0_ready | req1_ready;

    // Operand mux feeding the single shared ALU
    always_comb begin
        sel_rs1  = req0_rs1;
        sel_rs2  = req0_rs2;
        sel_ctrl = req0_ctrl;
        sel_tag  = req0_tag;
        if (grant1) begin
            sel_rs1  = req1_rs1;
            sel_rs2  = req1_rs2;
            sel_ctrl = req1_ctrl;
            sel_tag  = req1_tag;
        end
        alu_rd   = alu_op(sel_ctrl, sel_rs1, sel_rs2);
        alu_zero = (sel_rs1 == sel_rs2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            rsp_rd   <= '0;
            rsp_zero <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_tag  <= '0;
`ifdef ALU_ARBITER_RR_EN
            prio     <= 1'b0;
`endif
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) state <= FULL;
                end
                FULL: begin
                    if (rsp_ready && !accept) state <= EMPTY;
                end
                default: state <= EMPTY;
            endcase
            if (accept) begin
                rsp_rd   <= alu_rd;
                rsp_zero <= alu_zero;
                rsp_id   <= grant1;
                rsp_tag  <= sel_tag;
`ifdef ALU_ARBITER_RR_EN
                prio     <= !grant1;
`endif
            end
        end
    end

endmodule
